// File: rtl/fc_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the fully connected layer output path.
package fc_pkg;

    localparam int DW = 8;

    typedef logic [DW-1:0] fc_elem_t;

    typedef enum logic {
        IDLE,
        STREAM
    } fc_stream_state_e;

endpackage

// File: rtl/fc_output_streamer_if.sv
`timescale 1ns/1ps
// Bundles the parallel vector input and the element-serial output stream of fc_output_streamer.
interface fc_output_streamer_if #(
    parameter int M  = 5,
    parameter int DW = fc_pkg::DW,
    parameter int IW = $clog2(M)
);

    logic            vec_valid;
    logic            vec_ready;
    logic [M*DW-1:0] vec_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic [IW-1:0]   out_argmax;

    // The master feeds vectors and consumes the stream; the streamer is the slave.
    modport master (
        output vec_valid, vec_data, out_ready,
        input  vec_ready, out_valid, out_data, out_index, out_last, out_argmax
    );

    modport slave (
        input  vec_valid, vec_data, out_ready,
        output vec_ready, out_valid, out_data, out_index, out_last, out_argmax
    );

endinterface

// File: rtl/fc_argmax_tracker.sv
`timescale 1ns/1ps
// Running maximum over the accepted beats of one vector; reports the argmax
// including the candidate currently on the bus.
module fc_argmax_tracker #(
    parameter int DW = fc_pkg::DW,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          update_i,
    input  logic [DW-1:0] data_i,
    input  logic [IW-1:0] index_i,
    output logic [IW-1:0] argmax_o
);
    import fc_pkg::*;

    logic [DW-1:0] run_max_q, run_max_d;
    logic [IW-1:0] run_idx_q, run_idx_d;

    // Strict greater-than keeps the earliest index on ties; index 0 always seeds the max.
    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if (clear_i) begin
            run_max_d = '0;
            run_idx_d = '0;
        end else if (update_i && ((data_i > run_max_q) || (index_i == '0))) begin
            run_max_d = data_i;
            run_idx_d = index_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_max_q <= '0;
            run_idx_q <= '0;
        end else begin
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
        end
    end

    assign argmax_o = (data_i > run_max_q) ? index_i : run_idx_q;

endmodule

// File: rtl/fc_output_streamer.sv
`timescale 1ns/1ps
// Captures an M-wide result vector and replays it one element per handshake,
// tagging each beat with its index and the final beat with the vector argmax.
module fc_output_streamer #(
    parameter int M  = 5,
    parameter int DW = fc_pkg::DW,
    parameter int IW = $clog2(M)
) (
    input logic                clk,
    input logic                rst_n,
    fc_output_streamer_if.slave bus
);
    import fc_pkg::*;

    localparam logic [IW-1:0] LAST = IW'(M - 1);

    fc_stream_state_e     state_q, state_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [M-1:0][DW-1:0] buf_q;
    logic                 capture;
    logic                 clear;
    logic                 update;
    logic [DW-1:0]        cur;
    logic [IW-1:0]        argmax;

    assign cur = buf_q[cnt_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Buffer contents after reset are irrelevant; it is only read in STREAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= bus.vec_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        clear   = 1'b0;
        update  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.vec_valid) begin
                    capture = 1'b1;
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    update = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fc_argmax_tracker #(
        .DW(DW),
        .IW(IW)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .update_i (update),
        .data_i   (cur),
        .index_i  (cnt_q),
        .argmax_o (argmax)
    );

    // Outputs are decoded from registers only, and forced to zero outside STREAM.
    assign bus.vec_ready  = (state_q == IDLE);
    assign bus.out_valid  = (state_q == STREAM);
    assign bus.out_data   = (state_q == STREAM) ? cur : '0;
    assign bus.out_index  = (state_q == STREAM) ? cnt_q : '0;
    assign bus.out_last   = (state_q == STREAM) && (cnt_q == LAST);
    assign bus.out_argmax = ((state_q == STREAM) && (cnt_q == LAST)) ? argmax : '0;

endmodule

// File: tb/tb_fc_output_streamer.sv
`timescale 1ns/1ps
// Self-checking bench for fc_output_streamer: directed scenarios at M=5 and
// randomized sweeps at M=2 and M=8 against a lowest-index-max reference model.
module tb_fc_output_streamer;
    import fc_pkg::*;

    typedef struct {
        logic       valid;
        fc_elem_t   data;
        logic [2:0] idx;
        logic       last;
        logic [2:0] arg;
        logic       rdy;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    nChecks = 0;
    int    nFails  = 0;
    snap_t cyc[$];

    always #5 clk = ~clk;

    fc_output_streamer_if #(.M(5)) bus5 ();
    fc_output_streamer_if #(.M(2)) bus2 ();
    fc_output_streamer_if #(.M(8)) bus8 ();

    fc_output_streamer #(.M(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
    fc_output_streamer #(.M(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    fc_output_streamer #(.M(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // Reference: index of the first occurrence of the largest element.
    function automatic int refArgmax(input fc_elem_t v[8], input int n);
        int best = 0;
        for (int i = 1; i < n; i++) begin
            if (v[i] > v[best]) best = i;
        end
        return best;
    endfunction

    function automatic logic [63:0] packVec(input fc_elem_t v[8]);
        logic [63:0] p = '0;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = v[i];
        return p;
    endfunction

    task automatic start5(input fc_elem_t v[8]);
        logic [63:0] p;
        p = packVec(v);
        bus5.vec_data  = p[39:0];
        bus5.vec_valid = 1'b1;
        bus5.out_ready = 1'b0;
        @(negedge clk);
        bus5.vec_valid = 1'b0;
    endtask

    // Records one snapshot per cycle until the last beat is accepted; stalls beat stallBeat.
    task automatic drain5(input int stallBeat, input int stallCycles, output int timedOut);
        snap_t s;
        int    stalls;
        logic  done;
        cyc.delete();
        stalls   = stallCycles;
        timedOut = 1;
        for (int c = 0; c < 200; c++) begin
            s.valid = bus5.out_valid;
            s.data  = bus5.out_data;
            s.idx   = bus5.out_index;
            s.last  = bus5.out_last;
            s.arg   = bus5.out_argmax;
            s.rdy   = 1'b1;
            if (bus5.out_valid && (int'(bus5.out_index) == stallBeat) && (stalls > 0)) begin
                s.rdy = 1'b0;
                stalls--;
            end
            bus5.out_ready = s.rdy;
            cyc.push_back(s);
            done = bus5.out_valid && s.rdy && bus5.out_last;
            @(negedge clk);
            if (done) begin
                timedOut = 0;
                break;
            end
        end
        bus5.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if ({bus5.out_valid, bus5.vec_ready, bus5.out_last} !== 3'b010) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl: valid/ready/last=%b required 010", {bus5.out_valid, bus5.vec_ready, bus5.out_last});
        end
        nChecks++;
        if ({bus5.out_data, bus5.out_index, bus5.out_argmax} !== 14'd0) begin
            nFails++;
            $display("[TB] FAIL reset_data: data=%0d index=%0d argmax=%0d required 0", bus5.out_data, bus5.out_index, bus5.out_argmax);
        end
        nChecks++;
        if ({bus2.out_valid, bus2.vec_ready, bus8.out_valid, bus8.vec_ready} !== 4'b0101) begin
            nFails++;
            $display("[TB] FAIL reset_sweep_duts: got %b required 0101", {bus2.out_valid, bus2.vec_ready, bus8.out_valid, bus8.vec_ready});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fc_elem_t v[8];
        int to, k;
        v = '{8'd3, 8'd9, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        start5(v);
        drain5(-1, 0, to);
        nChecks++;
        if (to != 0 || cyc.size() != 5) begin
            nFails++;
            $display("[TB] FAIL basic_len: cycles=%0d timeout=%0d required 5 cycles", cyc.size(), to);
        end
        k = 0;
        foreach (cyc[c]) begin
            if (cyc[c].valid && cyc[c].rdy) begin
                nChecks++;
                if ({cyc[c].data, cyc[c].idx, cyc[c].last, cyc[c].arg} !==
                    {v[k], 3'(k), (k == 4), (k == 4) ? 3'(refArgmax(v, 5)) : 3'd0}) begin
                    nFails++;
                    $display("[TB] FAIL basic_beat%0d: data=%0d idx=%0d last=%b arg=%0d required %0d/%0d/%b/%0d",
                             k, cyc[c].data, cyc[c].idx, cyc[c].last, cyc[c].arg,
                             v[k], k, (k == 4), (k == 4) ? refArgmax(v, 5) : 0);
                end
                k++;
            end
        end
        nChecks++;
        if ({bus5.vec_ready, bus5.out_valid} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL basic_return_idle: ready/valid=%b required 10", {bus5.vec_ready, bus5.out_valid});
        end
    endtask

    task automatic test_extremes();
        fc_elem_t v[8];
        int to;
        for (int t = 0; t < 2; t++) begin
            v = (t == 0) ? '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0}
                         : '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
            start5(v);
            drain5(-1, 0, to);
            nChecks++;
            if (to != 0 || cyc.size() != 5 || {cyc[cyc.size()-1].last, cyc[cyc.size()-1].data, cyc[cyc.size()-1].arg} !==
                {1'b1, v[4], 3'(refArgmax(v, 5))}) begin
                nFails++;
                $display("[TB] FAIL extremes_%0d: cycles=%0d last=%b data=%0d arg=%0d required 5/1/%0d/%0d",
                         t, cyc.size(), cyc[cyc.size()-1].last, cyc[cyc.size()-1].data,
                         cyc[cyc.size()-1].arg, v[4], refArgmax(v, 5));
            end
        end
    endtask

    task automatic test_backpressure();
        fc_elem_t v[8];
        int to, held, k;
        v = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0, 8'd0};
        start5(v);
        drain5(2, 3, to);
        nChecks++;
        if (to != 0 || cyc.size() != 8) begin
            nFails++;
            $display("[TB] FAIL bp_len: cycles=%0d timeout=%0d required 8 cycles", cyc.size(), to);
        end
        held = 0;
        k    = 0;
        foreach (cyc[c]) begin
            if (cyc[c].valid && !cyc[c].rdy) begin
                held++;
                nChecks++;
                if ({cyc[c].data, cyc[c].idx, cyc[c].last} !== {8'd30, 3'd2, 1'b0}) begin
                    nFails++;
                    $display("[TB] FAIL bp_hold: data=%0d idx=%0d last=%b required 30/2/0", cyc[c].data, cyc[c].idx, cyc[c].last);
                end
            end
            if (cyc[c].valid && cyc[c].rdy) begin
                nChecks++;
                if ({cyc[c].data, cyc[c].idx} !== {v[k], 3'(k)}) begin
                    nFails++;
                    $display("[TB] FAIL bp_beat%0d: data=%0d idx=%0d required %0d/%0d", k, cyc[c].data, cyc[c].idx, v[k], k);
                end
                k++;
            end
        end
        nChecks++;
        if (held != 3 || cyc[cyc.size()-1].arg !== 3'd4) begin
            nFails++;
            $display("[TB] FAIL bp_summary: stalled=%0d arg=%0d required 3/4", held, cyc[cyc.size()-1].arg);
        end
    endtask

    task automatic test_back_to_back();
        fc_elem_t a[8], b[8];
        logic [63:0] pa, pb;
        int k, to;
        for (int i = 0; i < 8; i++) begin
            a[i] = fc_elem_t'($urandom_range(0, 127));
            b[i] = fc_elem_t'($urandom_range(128, 255));
        end
        pa = packVec(a);
        pb = packVec(b);
        bus5.vec_data  = pa[39:0];
        bus5.vec_valid = 1'b1;
        @(negedge clk);
        bus5.vec_data  = pb[39:0];
        bus5.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            if (bus5.out_valid) begin
                nChecks++;
                if ({bus5.out_data, bus5.out_index} !== {a[k], 3'(k)}) begin
                    nFails++;
                    $display("[TB] FAIL b2b_first%0d: data=%0d idx=%0d required %0d/%0d", k, bus5.out_data, bus5.out_index, a[k], k);
                end
                k++;
            end
            @(negedge clk);
        end
        bus5.out_ready = 1'b0;
        nChecks++;
        if ({bus5.vec_ready, bus5.out_valid} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL b2b_gap: ready/valid=%b required 10", {bus5.vec_ready, bus5.out_valid});
        end
        @(negedge clk);
        bus5.vec_valid = 1'b0;
        nChecks++;
        if ({bus5.out_valid, bus5.out_index, bus5.out_data} !== {1'b1, 3'd0, b[0]}) begin
            nFails++;
            $display("[TB] FAIL b2b_second_start: valid=%b idx=%0d data=%0d required 1/0/%0d", bus5.out_valid, bus5.out_index, bus5.out_data, b[0]);
        end
        drain5(-1, 0, to);
        nChecks++;
        if (to != 0 || cyc.size() != 5 || cyc[4].data !== b[4] || cyc[4].arg !== 3'(refArgmax(b, 5))) begin
            nFails++;
            $display("[TB] FAIL b2b_second: cycles=%0d data4=%0d arg=%0d required 5/%0d/%0d",
                     cyc.size(), cyc[cyc.size()-1].data, cyc[cyc.size()-1].arg, b[4], refArgmax(b, 5));
        end
    endtask

    task automatic test_reset_midstream();
        fc_elem_t v[8];
        int to;
        logic seen, sawLast;
        v = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd0, 8'd0, 8'd0};
        start5(v);
        bus5.out_ready = 1'b1;
        seen    = 1'b0;
        sawLast = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus5.out_valid && bus5.out_index == 3'd2) seen = 1'b1;
            if (bus5.out_last) sawLast = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        nChecks++;
        if (!seen || sawLast || {bus5.out_valid, bus5.vec_ready, bus5.out_last, bus5.out_index, bus5.out_data, bus5.out_argmax} !== 17'b01000000000000000) begin
            nFails++;
            $display("[TB] FAIL midreset_outputs: seen=%b lastEarly=%b valid=%b ready=%b last=%b idx=%0d data=%0d arg=%0d required reset values",
                     seen, sawLast, bus5.out_valid, bus5.vec_ready, bus5.out_last, bus5.out_index, bus5.out_data, bus5.out_argmax);
        end
        rst_n = 1'b1;
        bus5.out_ready = 1'b0;
        v = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        start5(v);
        drain5(-1, 0, to);
        nChecks++;
        if (to != 0 || cyc.size() != 5 || cyc[0].idx !== 3'd0 || cyc[0].data !== 8'd5 || cyc[4].arg !== 3'(refArgmax(v, 5))) begin
            nFails++;
            $display("[TB] FAIL midreset_restream: cycles=%0d idx0=%0d data0=%0d arg=%0d required 5/0/5/%0d",
                     cyc.size(), cyc[0].idx, cyc[0].data, cyc[cyc.size()-1].arg, refArgmax(v, 5));
        end
    endtask

    task automatic test_sweep_m2();
        fc_elem_t v[8];
        logic [63:0] p;
        int beat, expArg;
        logic rdy, timedOut;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++) v[i] = fc_elem_t'((n % 2) ? $urandom_range(0, 3) : $urandom_range(0, 255));
            expArg = refArgmax(v, 2);
            p = packVec(v);
            bus2.vec_data  = p[15:0];
            bus2.vec_valid = 1'b1;
            @(negedge clk);
            bus2.vec_valid = 1'b0;
            beat     = 0;
            timedOut = 1'b1;
            for (int c = 0; c < 100; c++) begin
                rdy = 1'($urandom_range(0, 1));
                if (bus2.out_valid && rdy) begin
                    nChecks++;
                    if ({bus2.out_data, bus2.out_index, bus2.out_last, bus2.out_argmax} !==
                        {v[beat], 1'(beat), (beat == 1), (beat == 1) ? 1'(expArg) : 1'b0}) begin
                        nFails++;
                        $display("[TB] FAIL m2_vec%0d_beat%0d: data=%0d idx=%0d last=%b arg=%0d required %0d/%0d/%b/%0d",
                                 n, beat, bus2.out_data, bus2.out_index, bus2.out_last, bus2.out_argmax,
                                 v[beat], beat, (beat == 1), (beat == 1) ? expArg : 0);
                    end
                    beat++;
                end
                bus2.out_ready = rdy;
                @(negedge clk);
                if (beat == 2) begin
                    timedOut = 1'b0;
                    break;
                end
            end
            bus2.out_ready = 1'b0;
            nChecks++;
            if (timedOut) begin
                nFails++;
                $display("[TB] FAIL m2_vec%0d_timeout: beats=%0d required 2", n, beat);
            end
        end
    endtask

    task automatic test_sweep_m8();
        fc_elem_t v[8];
        logic [63:0] p;
        int beat, expArg;
        logic rdy, timedOut, prevStall;
        fc_elem_t prevData;
        logic [2:0] prevIdx;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++) v[i] = fc_elem_t'((n % 2) ? $urandom_range(0, 3) : $urandom_range(0, 255));
            expArg = refArgmax(v, 8);
            p = packVec(v);
            bus8.vec_data  = p;
            bus8.vec_valid = 1'b1;
            @(negedge clk);
            bus8.vec_valid = 1'b0;
            beat      = 0;
            timedOut  = 1'b1;
            prevStall = 1'b0;
            prevData  = '0;
            prevIdx   = '0;
            for (int c = 0; c < 200; c++) begin
                rdy = 1'($urandom_range(0, 1));
                if (prevStall) begin
                    nChecks++;
                    if ({bus8.out_valid, bus8.out_data, bus8.out_index} !== {1'b1, prevData, prevIdx}) begin
                        nFails++;
                        $display("[TB] FAIL m8_hold: valid=%b data=%0d idx=%0d required 1/%0d/%0d",
                                 bus8.out_valid, bus8.out_data, bus8.out_index, prevData, prevIdx);
                    end
                end
                if (bus8.out_valid && rdy) begin
                    nChecks++;
                    if ({bus8.out_data, bus8.out_index, bus8.out_last, bus8.out_argmax} !==
                        {v[beat], 3'(beat), (beat == 7), (beat == 7) ? 3'(expArg) : 3'd0}) begin
                        nFails++;
                        $display("[TB] FAIL m8_vec%0d_beat%0d: data=%0d idx=%0d last=%b arg=%0d required %0d/%0d/%b/%0d",
                                 n, beat, bus8.out_data, bus8.out_index, bus8.out_last, bus8.out_argmax,
                                 v[beat], beat, (beat == 7), (beat == 7) ? expArg : 0);
                    end
                    beat++;
                end
                prevStall      = bus8.out_valid && !rdy;
                prevData       = bus8.out_data;
                prevIdx        = bus8.out_index;
                bus8.out_ready = rdy;
                @(negedge clk);
                if (beat == 8) begin
                    timedOut = 1'b0;
                    break;
                end
            end
            bus8.out_ready = 1'b0;
            nChecks++;
            if (timedOut) begin
                nFails++;
                $display("[TB] FAIL m8_vec%0d_timeout: beats=%0d required 8", n, beat);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus5.vec_valid = 1'b0;
        bus5.vec_data  = '0;
        bus5.out_ready = 1'b0;
        bus2.vec_valid = 1'b0;
        bus2.vec_data  = '0;
        bus2.out_ready = 1'b0;
        bus8.vec_valid = 1'b0;
        bus8.vec_data  = '0;
        bus8.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_sweep_m2();
        test_sweep_m8();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fc_output_streamer.md
# fc_output_streamer

Drains the parallel result vector of the fully connected layer and emits it as an element-serial valid/ready stream. Each element carries its index, and the last beat carries `out_last` plus the argmax of the whole vector. It sits between the fully connected layer output and the downstream classifier or DMA path, converting the layer's M-wide parallel bus into one 8-bit element per handshake.

## Interface
- `M`, default 5: number of elements per vector (≥2).
- `DW`, default 8: element width in bits; elements are unsigned.
- `IW`, default `$clog2(M)`: index width.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `vec_valid`  in  1: a result vector is present on `vec_data`.
- `vec_ready`  out  1: the block will capture `vec_data` on this edge if `vec_valid` is high.
- `vec_data`  in  M*DW: element i occupies `[i*DW +: DW]`.
- `out_valid`  out  1: a stream beat is presented.
- `out_ready`  in  1: the downstream accepts the beat.
- `out_data`  out  DW: element value.
- `out_index`  out  IW: element index, 0..M-1.
- `out_last`  out  1: high only on the beat with index M-1.
- `out_argmax`  out  IW: index of the maximum element of the vector; meaningful only when `out_last` is high, and held at 0 otherwise.

## Operation
- FSM with two states.
  - IDLE: `vec_ready=1`. On `vec_valid`, capture all M elements into a buffer, clear the beat counter, clear the running max (value 0, index 0), and go to STREAM.
  - STREAM: `out_valid=1`, `vec_ready=0`. `out_data=buf[cnt]`, `out_index=cnt`, `out_last=(cnt==M-1)`.
- Handshake = `out_valid && out_ready`. On a handshake:
  - If `out_data > run_max`, or `cnt==0`, load `run_max`/`run_idx` with `out_data`/`cnt`.
  - If `cnt==M-1`, go to IDLE; otherwise increment `cnt`.
- `out_argmax` on the last beat is combinational: `(buf[M-1] > run_max) ? M-1 : run_idx`.
- Ties resolve to the lowest index, because the comparison is strict greater-than.
- Comparisons are unsigned DW-bit. There is no arithmetic growth.
- While `out_valid && !out_ready`, all `out_*` signals hold stable. The buffer is never modified in STREAM.
- `vec_valid` in STREAM is ignored; `vec_ready=0` there, so no capture occurs.
- Reset values when `rst_n` is sampled low:
  - State returns to IDLE.
  - `cnt=0`, `run_max=0`, `run_idx=0`.
  - Outputs: `out_valid=0`, `out_last=0`, `out_index=0`, `out_data=0`, `out_argmax=0`, `vec_ready=1` from the next cycle.
  - Buffer contents are don't-care.
- Reset mid-stream discards the vector. No partial `out_last` is produced afterwards.
- A reset edge wins over a simultaneous capture or handshake.

## Timing
- Capture at edge t puts the first beat (index 0) valid in the cycle after t.
- Vector throughput with `out_ready` held high is M+1 cycles: M beats plus one IDLE capture cycle.
- The final handshake at edge u returns the block to IDLE, so `vec_ready=1` in the cycle after u. The next capture can occur at edge u+1.
- `vec_ready` and every `out_*` signal except `out_argmax` are functions of registers only. There is no combinational path from `out_ready` or `vec_valid` to any output.
- `out_argmax` depends only on registers (buffer, `run_max`, `run_idx`, `cnt`).

## Structure
- Shared package `fc_pkg` holds:
  - `DW`.
  - The element typedef `fc_elem_t` (`logic [DW-1:0]`).
  - The FSM enum `fc_stream_state_e` (IDLE, STREAM).
- One natural sub-module, `fc_argmax_tracker`, owns `run_max`/`run_idx`. Its inputs are clear, update-enable, data and index; its output is the final argmax including the current candidate.
- Top level holds the FSM, buffer and counter.

## Test plan
- Vector [3,9,9,1,0], `out_ready` held high. Required response:
  - Beats (3,0), (9,1), (9,2), (1,3), (0,4).
  - `out_last` only on index 4.
  - `out_argmax=1` (tie goes to the lower index).
  - `vec_ready` returns high in the cycle after beat 4.
- Vector [0,0,0,0,255] → `out_argmax=4` on the last beat. Also all-zero vector [0,0,0,0,0] → `out_argmax=0`.
- Backpressure: vector [10,20,30,40,50] with `out_ready` low during the cycles beat 2 is presented, for 3 cycles. Required response: `out_data=30`, `out_index=2` held stable, and the total stream completes in 8 cycles.
- Held `vec_valid`: with two distinct vectors presented back-to-back, the second is captured exactly at the edge after the first vector's last handshake. `vec_valid` asserted during STREAM causes no capture and no corruption of the current beats.
- Reset mid-stream: `rst_n` low at the edge after beat 2. Required response:
  - Next cycle `out_valid=0`, `vec_ready=1`, all outputs at their reset values.
  - A new vector [5,4,3,2,1] then streams from index 0 with `out_argmax=0`.
- Sweep M=2 and M=8 with random vectors and random `out_ready`. Required response: the stream equals the input order, and `out_argmax` matches a lowest-index-max reference model.
